// File: rtl/serial_add_sub.sv
// rtl/serial_add_sub.sv - multi-cycle add/subtract, CHUNK bits per clock through a ripple chain
module serial_add_sub #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] op_a, op_b, res_sh, res_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [CHUNK:0]   c;
  logic [CHUNK-1:0] s;
  logic             accept, last;

  // Ripple chain of full-adder cells; c[CHUNK-1] is the carry into the operand MSB on the last chunk.
  assign c[0] = carry;
  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s[i]   = op_a[i] ^ op_b[i] ^ c[i];
    assign c[i+1] = (op_a[i] & op_b[i]) | (c[i] & (op_a[i] ^ op_b[i]));
  end

  if (CHUNK == WIDTH) begin : g_res_full
    assign res_next = s;
  end else begin : g_res_shift
    assign res_next = {s, res_sh[WIDTH-1:CHUNK]};
  end

  assign accept = start && (state == IDLE || state == FIN);
  assign last   = (state == RUN) && (cnt == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_next = FIN;
      end
      FIN: begin
        done       = 1'b1;
        state_next = start ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a   <= '0;
      op_b   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      co     <= 1'b0;
      ovf    <= 1'b0;
    end else if (accept) begin
      op_a  <= a;
      op_b  <= sub ? ~b : b;
      carry <= sub;
      cnt   <= '0;
    end else if (state == RUN) begin
      op_a   <= op_a >> CHUNK;
      op_b   <= op_b >> CHUNK;
      carry  <= c[CHUNK];
      cnt    <= cnt + 1'b1;
      res_sh <= res_next;
      // Results are published only here so partial sums never appear on the outputs.
      if (last) begin
        sum <= res_next;
        co  <= c[CHUNK];
        ovf <= c[CHUNK-1] ^ c[CHUNK];
      end
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// tb/tb_serial_add_sub.sv - randomized and directed checks of serial_add_sub at CHUNK=1 and CHUNK=4
module tb_serial_add_sub;

  logic       clk, rst, start1, start4, sub;
  logic [7:0] a, b;
  logic       busy1, done1, co1, ovf1, busy4, done4, co4, ovf4;
  logic [7:0] sum1, sum4;
  logic [9:0] prev1, prev4;
  int         n_cmp, n_bad;

  serial_add_sub #(.WIDTH(8), .CHUNK(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub), .a(a), .b(b),
    .busy(busy1), .done(done1), .sum(sum1), .co(co1), .ovf(ovf1)
  );

  serial_add_sub #(.WIDTH(8), .CHUNK(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub), .a(a), .b(b),
    .busy(busy4), .done(done4), .sum(sum4), .co(co4), .ovf(ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {ovf, co, sum} from integer arithmetic on the operand values.
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic s);
    logic [7:0] ny;
    int         full, sr;
    logic       v;
    ny   = ~y;
    full = s ? int'(x) + int'(ny) + 1 : int'(x) + int'(y);
    sr   = s ? int'($signed(x)) - int'($signed(y)) : int'($signed(x)) + int'($signed(y));
    v    = (sr > 127) || (sr < -128);
    return {v, full[8], full[7:0]};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input int cyc, input logic [9:0] e);
    check("busy1", {7'd0, busy1}, {7'd0, cyc <= 8});
    check("done1", {7'd0, done1}, {7'd0, cyc == 9});
    if (cyc == 9) prev1 = e;
    check("sum1", sum1, prev1[7:0]);
    check("co1",  {7'd0, co1},  {7'd0, prev1[8]});
    check("ovf1", {7'd0, ovf1}, {7'd0, prev1[9]});
    check("busy4", {7'd0, busy4}, {7'd0, cyc <= 2});
    check("done4", {7'd0, done4}, {7'd0, cyc == 3});
    if (cyc == 3) prev4 = e;
    check("sum4", sum4, prev4[7:0]);
    check("co4",  {7'd0, co4},  {7'd0, prev4[8]});
    check("ovf4", {7'd0, ovf4}, {7'd0, prev4[9]});
  endtask

  // One operation on both instances; poke re-pulses start1 with a=0xFF mid-run,
  // b2b launches in the current (DONE) cycle instead of waiting a cycle.
  task automatic run(input logic [7:0] ta, input logic [7:0] tb2, input logic ts,
                     input int poke, input bit b2b);
    logic [9:0] e;
    e = model(ta, tb2, ts);
    if (!b2b) @(negedge clk);
    a = ta; b = tb2; sub = ts; start1 = 1'b1; start4 = 1'b1;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(negedge clk);
      start1 = 1'b0; start4 = 1'b0;
      a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
      if (cyc == poke) begin
        start1 = 1'b1;
        a      = 8'hFF;
      end
      check_outs(cyc, e);
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    prev1 = '0; prev4 = '0;
    rst = 1'b1; start1 = 1'b0; start4 = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy1", {7'd0, busy1}, 8'd0);
    check("rst_done1", {7'd0, done1}, 8'd0);
    check("rst_sum1", sum1, 8'd0);
    check("rst_co1", {7'd0, co1}, 8'd0);
    check("rst_ovf1", {7'd0, ovf1}, 8'd0);
    check("rst_busy4", {7'd0, busy4}, 8'd0);
    check("rst_sum4", sum4, 8'd0);
    rst = 1'b0;

    run(8'h7F, 8'h01, 1'b0, 0, 1'b0);
    run(8'hFF, 8'h01, 1'b0, 0, 1'b0);
    run(8'h05, 8'h07, 1'b1, 0, 1'b0);
    run(8'h80, 8'h01, 1'b1, 0, 1'b0);
    run(8'h3C, 8'h4B, 1'b0, 0, 1'b0);
    run(8'h00, 8'h80, 1'b1, 0, 1'b0);
    repeat (24) run(8'($urandom), 8'($urandom), 1'($urandom), 0, 1'b0);

    run(8'h10, 8'h20, 1'b0, 3, 1'b0);
    run(8'h01, 8'h01, 1'b0, 0, 1'b1);

    // Reset asserted during cycle 4 of a run.
    @(negedge clk);
    a = 8'hA5; b = 8'h3C; sub = 1'b0; start1 = 1'b1; start4 = 1'b1;
    repeat (3) begin
      @(negedge clk);
      start1 = 1'b0; start4 = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_busy1", {7'd0, busy1}, 8'd0);
    check("mrst_done1", {7'd0, done1}, 8'd0);
    check("mrst_sum1", sum1, 8'd0);
    check("mrst_co1", {7'd0, co1}, 8'd0);
    check("mrst_ovf1", {7'd0, ovf1}, 8'd0);
    check("mrst_sum4", sum4, 8'd0);
    prev1 = '0; prev4 = '0;
    for (int k = 0; k < 10; k++) begin
      check("mrst_nodone1", {7'd0, done1}, 8'd0);
      @(negedge clk);
    end
    run(8'($urandom), 8'($urandom), 1'($urandom), 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
